store_queue_ctrl: RTL
=====================

Name: store_queue_ctrl

Overview:
Posted-store buffer and write scheduler between the core's byte-lane store formatter and the data-memory write port. It accepts formatted stores (word address, lane-aligned data, byte write mask) from the MEM stage and drains them in order to the memory port under a valid/ready handshake. It flags loads that hit a pending store so the core can stall, and provides a flush sequence used before fence/CSR-triggered memory reads.

Parameters:
DEPTH, 4, number of queue entries; power of two, >= 2
CW, 3, width of occupancy count; must equal clog2(DEPTH)+1

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
st_valid  in  1  store request from MEM stage
st_ready  out  1  queue can accept a store this cycle
st_addr  in  32  store byte address; only bits [31:2] are stored
st_data  in  32  lane-aligned store data
st_wmask  in  4  byte write mask
ld_valid  in  1  load in MEM stage
ld_addr  in  32  load byte address
ld_hazard  out  1  load must stall: pending store to same word
mem_req_valid  out  1  head entry presented to memory
mem_req_ready  in  1  memory accepts head entry
mem_addr  out  32  head word address, {addr[31:2],2'b00}
mem_data  out  32  head data
mem_wmask  out  4  head mask
flush_req  in  1  single-cycle request to drain the queue
flush_done  out  1  one-cycle pulse: queue empty after flush
count  out  CW  current occupancy

Behaviour:
- Reset: head/tail pointers 0, count 0, all entry valid bits 0, FSM IDLE; st_ready=1, mem_req_valid=0, mem_addr/data/wmask=0, ld_hazard=0, flush_done=0.
- Storage: circular buffer of DEPTH entries {addr[31:2], data, wmask}; pointers wrap modulo DEPTH.
- Enqueue: fires when st_valid && st_ready. If st_wmask==0, the request is acknowledged and discarded (no entry, count unchanged).
- st_ready = (count != DEPTH) && state==IDLE. Based on current count only: a full queue does not accept in the same cycle as a pop.
- Dequeue: mem_req_valid = (count != 0). mem_* are driven from head-entry registers and are 0 when empty. Pop fires on mem_req_valid && mem_req_ready. mem_* must stay stable while valid && !ready.
- Latency: a store enqueued into an empty queue appears on mem_req_valid the next cycle. There is no bypass.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Ordering: strict FIFO. Stores are never merged or reordered.
- Hazard (combinational): ld_hazard = ld_valid && any valid entry with entry.addr == ld_addr[31:2]. Includes the head entry while it is being popped. Does not include a store enqueueing in the same cycle; the core sequences stores before younger loads.
- Flush FSM:
  - IDLE -> DRAIN on flush_req.
  - DRAIN: st_ready=0; draining continues. Go to DONE when count==0 (checked registered, so an already-empty queue takes one DRAIN cycle).
  - DONE: flush_done=1 for exactly one cycle, then IDLE.
  - flush_req outside IDLE is ignored.
- rst asserted mid-drain or mid-flush: queue contents are discarded and the FSM returns to IDLE. Discarding in-flight stores is the intended reset behaviour.
- count is registered and updates the cycle after push/pop.

Optional Feature:
STORE_QUEUE_FWD_EN. When defined, adds outputs ld_fwd_data[31:0] and ld_fwd_mask[3:0].
- For a load matching pending entries, bytes are merged oldest to youngest, so the youngest write to each lane wins; ld_fwd_mask is the OR of the matching masks.
- ld_hazard then asserts only if the merged mask != 4'b1111. Full-word coverage is forwarded without a stall.
When undefined, these ports are absent and ld_hazard asserts on any word match.

Test Plan:
- Reset, then single store addr=0x104, data=0xAABBCCDD, mask=1111, mem_req_ready=1 -> mem_req_valid high the next cycle with mem_addr=0x104; count returns to 0 the cycle after the pop.
- mem_req_ready=0, push 5 stores with DEPTH=4 -> st_ready drops after the 4th; count=4; the 5th is held until ready=1; drain order is exactly the push order.
- Push addr=0x200 mask=0100, hold memory; load ld_addr=0x203 -> ld_hazard=1; ld_addr=0x204 -> ld_hazard=0.
- Store with st_wmask=0000 -> acknowledged; count stays 0; mem_req_valid never rises.
- 3 stores queued, flush_req pulse, memory ready every other cycle -> st_ready=0 during drain; flush_done pulses once, on the cycle after count reaches 0; state back to IDLE.
- FWD_EN: push 0x300 mask=0011 data=0x00001122, then 0x300 mask=1100 data=0x33440000; load 0x300 -> fwd_data=0x33441122, fwd_mask=1111, ld_hazard=0.

Source files
------------

// File: rtl/store_queue_ctrl.sv
// -----------------------------------------------------------------------------
// store_queue_ctrl
//   Posted-store buffer and write scheduler between the core's byte-lane store
//   formatter and the data-memory write port. Stores are held in a circular
//   buffer and drained strictly in order under a valid/ready handshake. Loads
//   that hit a pending store raise ld_hazard so the core can stall. A flush
//   sequence (IDLE -> DRAIN -> DONE) blocks new stores until the queue is
//   empty and then pulses flush_done for one cycle.
//
//   Optional build macro: STORE_QUEUE_FWD_EN
//     When defined, adds ld_fwd_data/ld_fwd_mask. Matching pending stores are
//     merged oldest to youngest, and ld_hazard asserts only when the merged
//     mask does not cover the full word.
// -----------------------------------------------------------------------------
module store_queue_ctrl #(
   parameter int DEPTH = 4,   // number of entries, power of two, >= 2
   parameter int CW    = 3    // occupancy width, clog2(DEPTH)+1
) (
   input  logic          clk,
   input  logic          rst,
   // store request from MEM stage
   input  logic          st_valid,
   output logic          st_ready,
   input  logic [31:0]   st_addr,
   input  logic [31:0]   st_data,
   input  logic [3:0]    st_wmask,
   // load hazard check
   input  logic          ld_valid,
   input  logic [31:0]   ld_addr,
   output logic          ld_hazard,
   // memory write port
   output logic          mem_req_valid,
   input  logic          mem_req_ready,
   output logic [31:0]   mem_addr,
   output logic [31:0]   mem_data,
   output logic [3:0]    mem_wmask,
   // flush sequence
   input  logic          flush_req,
   output logic          flush_done,
`ifdef STORE_QUEUE_FWD_EN
   output logic [31:0]   ld_fwd_data,
   output logic [3:0]    ld_fwd_mask,
`endif
   output logic [CW-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [29:0] addr;    // word address, byte address bits [31:2]
      logic [31:0] data;    // lane-aligned data
      logic [3:0]  wmask;   // byte write mask
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   entry_t           r_mem [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;
   state_t           r_state;

   // ---------------------------------------------------------------------------
   // Combinational nets
   // ---------------------------------------------------------------------------
   state_t           w_state_nxt;
   logic             w_full;
   logic             w_empty;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   entry_t           w_head_entry;
   logic [DEPTH-1:0] w_match;
   logic             w_unused_lsbs;

   // Byte offsets are irrelevant to word-granular storage and matching.
   assign w_unused_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

   assign w_full   = (r_count == CW'(DEPTH));
   assign w_empty  = (r_count == '0);

   // A handshake with an all-zero mask is acknowledged but never stored.
   assign w_accept = st_valid && st_ready;
   assign w_push   = w_accept && (st_wmask != 4'b0000);
   assign w_pop    = mem_req_valid && mem_req_ready;

   assign count    = r_count;

   // ---------------------------------------------------------------------------
   // Memory-side outputs: head entry, forced to zero while the queue is empty
   // ---------------------------------------------------------------------------
   assign w_head_entry  = r_mem[r_head];
   assign mem_req_valid = !w_empty;
   assign mem_addr      = w_empty ? 32'h0 : {w_head_entry.addr, 2'b00};
   assign mem_data      = w_empty ? 32'h0 : w_head_entry.data;
   assign mem_wmask     = w_empty ? 4'h0  : w_head_entry.wmask;

   // Entry payload storage; written on push only.
   // NOTE: the payload array has no reset; r_vld and r_count alone decide
   //       whether an entry is meaningful, so stale data is never observed.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_tail] <= '{addr: st_addr[31:2], data: st_data, wmask: st_wmask};
      end
   end

   // Pointers, per-entry valid bits and occupancy count.
   // NOTE: sequential state is updated with non-blocking assignments so every
   //       register samples the pre-edge values of its inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_vld   <= '0;
      end else begin
         // Pop before push: with the queue neither full nor empty the two
         // pointers never alias, so the order only matters for clarity.
         if (w_pop) begin
            r_vld[r_head] <= 1'b0;
            r_head        <= r_head + PW'(1);
         end
         if (w_push) begin
            r_vld[r_tail] <= 1'b1;
            r_tail        <= r_tail + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Flush FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Flush FSM next-state and store-side outputs.
   // NOTE: every output of this block gets a default first so no path through
   //       the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      st_ready    = 1'b0;
      flush_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Accept only on current occupancy; a full queue stays closed even
            // in a cycle where the head is popped.
            st_ready = !w_full;
            if (flush_req) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Memory keeps draining through the normal pop path; the empty
            // test uses the registered count, so an already-empty queue still
            // spends one cycle here.
            if (w_empty) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            flush_done  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Per-entry word-address match against the load; the head entry counts
   // even while it is being popped, and a store enqueueing this cycle does not.
   always_comb begin
      w_match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_match[i] = r_vld[i] && (r_mem[i].addr == ld_addr[31:2]);
      end
   end

`ifdef STORE_QUEUE_FWD_EN
   logic [31:0] w_fwd_data;
   logic [3:0]  w_fwd_mask;

   // Merge matching entries oldest to youngest so the youngest write to each
   // byte lane wins; the merged mask is the OR of all matching masks.
   always_comb begin : fwd_merge
      logic [PW-1:0] idx;
      w_fwd_data = '0;
      w_fwd_mask = '0;
      idx        = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = r_head + PW'(k);
         if (w_match[idx]) begin
            for (int b = 0; b < 4; b++) begin
               if (r_mem[idx].wmask[b]) begin
                  w_fwd_data[8*b +: 8] = r_mem[idx].data[8*b +: 8];
               end
            end
            w_fwd_mask = w_fwd_mask | r_mem[idx].wmask;
         end
      end
   end

   assign ld_fwd_data = ld_valid ? w_fwd_data : 32'h0;
   assign ld_fwd_mask = ld_valid ? w_fwd_mask : 4'h0;
   // Full-word coverage is forwarded; only a partial cover must stall.
   assign ld_hazard   = ld_valid && (|w_match) && (w_fwd_mask != 4'b1111);
`else
   // Without forwarding any pending store to the same word stalls the load.
   assign ld_hazard   = ld_valid && (|w_match);
`endif

endmodule
